// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer that raises a CP0 hardware interrupt.
// Supports one-shot (held irq) and auto-reload (one-cycle irq pulse) modes.
module timer_irq_dev #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q, flag_d;

    logic               flag_set;
    logic               flag_clr;
    logic               en_clr;
    logic               ctrl_wr;
    logic               preset_wr;
    logic               en;
    logic [1:0]         mode;
    logic               cnt_last;

    assign en        = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);
    assign cnt_last  = (count_q[CNT_W-1:1] == '0);

    // Timer FSM next state plus bus writes; bus beats FSM on EN, flag set beats ack
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_set = 1'b0;
        flag_clr = 1'b0;
        en_clr   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_last) begin
                    count_d  = '0;
                    flag_set = 1'b1;
                    state_d  = S_INT;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_INT: begin
                if (mode == 2'd1) begin
                    flag_clr = 1'b1;
                    state_d  = S_LOAD;
                end else begin
                    en_clr  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (en_clr) begin
            ctrl_d[0] = 1'b0;
        end
        if (ctrl_wr) begin
            ctrl_d   = wdata[3:0];
            flag_clr = 1'b1;
        end
        if (preset_wr) begin
            preset_d = wdata[CNT_W-1:0];
        end

        if (flag_set) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // State and register file with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Combinational register read, narrow fields zero-extended
    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0:    rdata = {28'd0, ctrl_q};
            2'd1:    rdata = 32'(preset_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = '0;
        endcase
    end

    assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq_dev.sv
// Directed self-checking bench for timer_irq_dev.
// Each task drives one scenario and compares against hand-derived values.
`timescale 1ns/1ps
module tb_timer_irq_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int errors;

    timer_irq_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_rd%0d got %h want 0", a, v);
            end
        end
        reset = 1'b1;
        bus_wr(2'd3, 32'hFFFF_FFFF);
        bus_wr(2'd2, 32'h0000_0055);
        bus_wr(2'd0, 32'hFFFF_FFF8);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL ctrl_upper got %h want 8", v);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL count_ro got %h want 0", v);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL rsvd got %h want 0", v);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_wr(2'd1, 32'd5);
        bus_wr(2'd0, 32'h9);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (v !== 32'(5 - k) || irq !== 1'b0) begin
                errors++;
                $display("FAIL os_count%0d got %0d/%b want %0d/0",
                         k, v, irq, 5 - k);
            end
        end
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL os_expire got %0d/%b want 0/1", v, irq);
        end
        tick();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL os_ctrl got %h want 8", v);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL os_hold%0d got %b want 1", k, irq);
            end
        end
        bus_wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL os_ack got %b want 0", irq);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        int pulses;
        int m;
        logic [31:0] exp_c;
        logic exp_i;
        pulses = 0;
        do_reset();
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'hB);
        for (int n = 1; n <= 21; n++) begin
            tick();
            exp_i = (n >= 5) && ((n - 5) % 5 == 0);
            if (irq === 1'b1) pulses++;
            checks++;
            if (irq !== exp_i) begin
                errors++;
                $display("FAIL ar_irq n=%0d got %b want %b", n, irq, exp_i);
            end
            if (n >= 2) begin
                m = (n - 2) % 5;
                exp_c = (m < 3) ? 32'(3 - m) : 32'd0;
                rd(2'd2, v);
                checks++;
                if (v !== exp_c) begin
                    errors++;
                    $display("FAIL ar_cnt n=%0d got %0d want %0d",
                             n, v, exp_c);
                end
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL ar_pulses got %0d want 4", pulses);
        end
        bus_wr(2'd0, 32'h0);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        do_reset();
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'h1);
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq n=%0d got %b want 0", n, irq);
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mask_ctrl got %h want 0", v);
        end
        bus_wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask got %b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_after got %b want 0", irq);
        end
    endtask

    task automatic test_pause_preset();
        logic [31:0] v;
        do_reset();
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'h9);
        repeat (4) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd8) begin
            errors++;
            $display("FAIL pause_pre got %0d want 8", v);
        end
        bus_wr(2'd0, 32'h8);
        repeat (3) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd7 || irq !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold got %0d/%b want 7/0", v, irq);
        end
        bus_wr(2'd1, 32'd2);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL preset_nochg got %0d want 7", v);
        end
        bus_wr(2'd0, 32'h9);
        tick();
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL reload got %0d want 2", v);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reload_early got %b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL reload_irq got %b want 1", irq);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        do_reset();
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'h9);
        repeat (4) tick();
        bus_wr(2'd0, 32'h9);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL col_set got %b want 1", irq);
        end
        bus_wr(2'd0, 32'h9);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h9 || irq !== 1'b0) begin
            errors++;
            $display("FAIL col_en got %h/%b want 9/0", v, irq);
        end
        tick();
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL col_reload got %0d want 3", v);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        do_reset();
        bus_wr(2'd1, 32'd6);
        bus_wr(2'd0, 32'h9);
        repeat (4) tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL ar_mid_irq got %b want 0", irq);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL ar_mid_cnt got %0d want 0", v);
        end
        tick();
        reset = 1'b1;
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd0, 32'h9);
        repeat (4) tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre_irq got %b want 1", irq);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL ar_drop got %b want 0", irq);
        end
        tick();
        reset = 1'b1;
        tick();
        rd(2'd0, v);
        checks++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL ar_post got %h/%b want 0/0", v, irq);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        wdata  = '0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_pause_preset();
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
